// File: rtl/overlap_add_engine.sv
// Overlap/add sequencer for the AAC decoder: for each frame it reads the current window first half
// and the previous window second half from a per-channel slot ring, and streams the saturated sum.
module overlap_add_engine #(
  parameter int WIN_LEN   = 1024,
  parameter int WORD_LEN  = 16,
  parameter int NUM_SLOTS = 4,
  parameter int NUM_CH    = 2,
  parameter int ADDR_W    = 16,
  parameter int ADDR_BASE = 0,
  localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [CH_W-1:0]     ch_sel,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   cur_addr,
  output logic [ADDR_W-1:0]   prev_addr,
  output logic                mem_rd_en,
  input  logic [WORD_LEN-1:0] cur_data,
  input  logic [WORD_LEN-1:0] prev_data,
  output logic [WORD_LEN-1:0] out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int HALF_LEN = WIN_LEN / 2;
  localparam int IDX_W    = $clog2(HALF_LEN);
  localparam int SLOT_W   = $clog2(NUM_SLOTS);
  localparam logic [IDX_W-1:0]    LAST_IDX = IDX_W'(HALF_LEN - 1);
  localparam logic [WORD_LEN-1:0] SAT_MAX  = {1'b0, {(WORD_LEN-1){1'b1}}};
  localparam logic [WORD_LEN-1:0] SAT_MIN  = {1'b1, {(WORD_LEN-1){1'b0}}};

  typedef enum logic [2:0] {IDLE, FETCH, WAIT_MEM, OUT, DONE} stateT;

  stateT             stateQ, stateD;
  logic [CH_W-1:0]   chQ;
  logic [IDX_W-1:0]  idxQ;
  logic [SLOT_W-1:0] slotQ [NUM_CH];
  logic              firstFrameQ [NUM_CH];

  logic              startOk;
  logic [CH_W-1:0]   fetchCh;
  logic [IDX_W-1:0]  fetchIdx;
  logic [SLOT_W-1:0] fetchSlot, prevSlot;
  logic [WORD_LEN:0] sumWide;
  logic [WORD_LEN-1:0] satSum;

  // Offset within the ring region: ((ch*NUM_SLOTS + slot)*WIN_LEN) + offset
  function automatic logic [ADDR_W-1:0] addrOf(input logic [CH_W-1:0] ch,
                                               input logic [SLOT_W-1:0] slot,
                                               input logic [IDX_W:0] offset);
    return ADDR_W'(ADDR_BASE + (32'(ch) * NUM_SLOTS + 32'(slot)) * WIN_LEN) + ADDR_W'(offset);
  endfunction

  assign startOk = start && (32'(ch_sel) < NUM_CH);

  always_comb begin
    stateD = stateQ;
    busy   = (stateQ != IDLE);
    done   = (stateQ == DONE);
    case (stateQ)
      IDLE:     if (startOk) stateD = FETCH;
      FETCH:    stateD = WAIT_MEM;
      WAIT_MEM: stateD = OUT;
      OUT:      if (out_ready) stateD = (idxQ == LAST_IDX) ? DONE : FETCH;
      DONE:     stateD = IDLE;
      default:  stateD = IDLE;
    endcase
  end

  // Addresses for the next fetch: the first sample when a frame is accepted, otherwise idx+1
  always_comb begin
    fetchCh  = chQ;
    fetchIdx = idxQ + IDX_W'(1);
    if (stateQ == IDLE) begin
      fetchCh  = ch_sel;
      fetchIdx = '0;
    end
    fetchSlot = slotQ[fetchCh];
    prevSlot  = fetchSlot - SLOT_W'(1);
  end

  // The previous half is masked on a channel's first frame since no earlier window exists yet
  always_comb begin
    sumWide = {cur_data[WORD_LEN-1], cur_data}
            + (firstFrameQ[chQ] ? '0 : {prev_data[WORD_LEN-1], prev_data});
    satSum  = sumWide[WORD_LEN-1:0];
    if (sumWide[WORD_LEN] != sumWide[WORD_LEN-1])
      satSum = sumWide[WORD_LEN] ? SAT_MIN : SAT_MAX;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stateQ    <= IDLE;
      chQ       <= '0;
      idxQ      <= '0;
      cur_addr  <= '0;
      prev_addr <= '0;
      mem_rd_en <= 1'b0;
      out_data  <= '0;
      out_valid <= 1'b0;
      for (int c = 0; c < NUM_CH; c++) begin
        slotQ[c]       <= '0;
        firstFrameQ[c] <= 1'b1;
      end
    end else begin
      stateQ    <= stateD;
      mem_rd_en <= 1'b0;
      case (stateQ)
        IDLE: begin
          if (startOk) begin
            chQ       <= ch_sel;
            idxQ      <= '0;
            cur_addr  <= addrOf(fetchCh, fetchSlot, {1'b0, fetchIdx});
            prev_addr <= addrOf(fetchCh, prevSlot, {1'b1, fetchIdx});
            mem_rd_en <= 1'b1;
          end
        end
        WAIT_MEM: begin
          out_data  <= satSum;
          out_valid <= 1'b1;
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            if (idxQ != LAST_IDX) begin
              idxQ      <= fetchIdx;
              cur_addr  <= addrOf(fetchCh, fetchSlot, {1'b0, fetchIdx});
              prev_addr <= addrOf(fetchCh, prevSlot, {1'b1, fetchIdx});
              mem_rd_en <= 1'b1;
            end
          end
        end
        DONE: begin
          slotQ[chQ]       <= slotQ[chQ] + SLOT_W'(1);
          firstFrameQ[chQ] <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
